// File: rtl/key_event.sv
// Key level to press/auto-repeat pulses plus a 4-digit BCD event counter.
// Define KEY_AUTOREPEAT_EN to enable auto-repeat (REPEAT state, hold/repeat timers).
module key_event #(
    parameter int unsigned HOLD_CYCLES   = 25_000_000,
    parameter int unsigned REPEAT_CYCLES = 5_000_000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        button_on,
    input  logic        clear,
    output logic        press,
    output logic        repeat_pulse,
    output logic        step,
    output logic [15:0] count_bcd,
    output logic        count_changed
);

    if (HOLD_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_param_check
        $error("key_event: HOLD_CYCLES and REPEAT_CYCLES must be >= 2");
    end

`ifdef KEY_AUTOREPEAT_EN
    localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES);
    localparam int unsigned REP_W  = $clog2(REPEAT_CYCLES);

    typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;

    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [REP_W-1:0]  rep_q, rep_d;
    logic              repeat_d;
`else
    typedef enum logic {IDLE, HOLD} state_t;
`endif

    state_t state_q, state_d;
    logic   btn_q;
    logic   press_d;
    logic   press_edge_c;

    // Released-to-pressed transition of the active-low key level
    assign press_edge_c = ~button_on & btn_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            btn_q   <= 1'b0;
`ifdef KEY_AUTOREPEAT_EN
            hold_q  <= '0;
            rep_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            btn_q   <= button_on;
`ifdef KEY_AUTOREPEAT_EN
            hold_q  <= hold_d;
            rep_q   <= rep_d;
`endif
        end
    end

    // Next state and pulse requests; a release always beats a due repeat
    always_comb begin
        state_d  = state_q;
        press_d  = 1'b0;
`ifdef KEY_AUTOREPEAT_EN
        repeat_d = 1'b0;
        hold_d   = hold_q;
        rep_d    = rep_q;
`endif
        case (state_q)
            IDLE: begin
                if (press_edge_c) begin
                    press_d = 1'b1;
                    state_d = HOLD;
`ifdef KEY_AUTOREPEAT_EN
                    hold_d  = '0;
`endif
                end
            end
            HOLD: begin
                if (button_on) begin
                    state_d = IDLE;
                end
`ifdef KEY_AUTOREPEAT_EN
                else if (hold_q == HOLD_W'(HOLD_CYCLES - 1)) begin
                    repeat_d = 1'b1;
                    state_d  = REPEAT;
                    rep_d    = '0;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
`endif
            end
`ifdef KEY_AUTOREPEAT_EN
            REPEAT: begin
                if (button_on) begin
                    state_d = IDLE;
                end else if (rep_q == REP_W'(REPEAT_CYCLES - 1)) begin
                    repeat_d = 1'b1;
                    rep_d    = '0;
                end else begin
                    rep_d = rep_q + REP_W'(1);
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            press <= 1'b0;
            step  <= 1'b0;
        end else begin
            press <= press_d;
`ifdef KEY_AUTOREPEAT_EN
            step  <= press_d | repeat_d;
`else
            step  <= press_d;
`endif
        end
    end

`ifdef KEY_AUTOREPEAT_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            repeat_pulse <= 1'b0;
        end else begin
            repeat_pulse <= repeat_d;
        end
    end
`else
    assign repeat_pulse = 1'b0;
`endif

    // Four-digit BCD increment, each digit wrapping 9 -> 0 with carry
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (r[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Clear takes priority over a simultaneous step
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_bcd     <= 16'h0000;
            count_changed <= 1'b0;
        end else if (clear) begin
            count_bcd     <= 16'h0000;
            count_changed <= 1'b1;
        end else if (step) begin
            count_bcd     <= bcd_inc(count_bcd);
            count_changed <= 1'b1;
        end else begin
            count_changed <= 1'b0;
        end
    end

endmodule

// File: tb/tb_key_event.sv
// Self-checking bench for key_event: directed scenarios plus random key/clear/reset
// traffic, compared every cycle against a behavioural model.
module tb_key_event;

    localparam int unsigned H = 10;
    localparam int unsigned R = 4;
`ifdef KEY_AUTOREPEAT_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        button_on = 1'b1;
    logic        clear = 1'b0;
    logic        press, repeat_pulse, step, count_changed;
    logic [15:0] count_bcd;

    key_event #(.HOLD_CYCLES(H), .REPEAT_CYCLES(R)) dut (
        .clock(clock), .reset_n(reset_n), .button_on(button_on), .clear(clear),
        .press(press), .repeat_pulse(repeat_pulse), .step(step),
        .count_bcd(count_bcd), .count_changed(count_changed)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;
    int n_press  = 0;
    int n_rep    = 0;
    int n_chg    = 0;

    // Model: key "held" flag, cycles since press, event count as an integer
    bit m_btn_q, m_held, m_press, m_rep, m_step, m_chg;
    int m_age, m_count;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic model_reset();
        m_btn_q = 0; m_held = 0; m_age = 0;
        m_press = 0; m_rep = 0; m_step = 0; m_chg = 0; m_count = 0;
    endtask

    task automatic model_edge();
        bit p, r;
        if (!reset_n) begin
            model_reset();
            return;
        end
        m_chg   = clear | m_step;
        m_count = clear ? 0 : (m_step ? (m_count + 1) % 10000 : m_count);
        p = 0; r = 0;
        if (!m_held) begin
            if (!button_on && m_btn_q) begin
                p = 1; m_held = 1; m_age = 0;
            end
        end else if (button_on) begin
            m_held = 0;
        end else begin
            m_age++;
            if (AUTO && m_age >= int'(H) && (m_age - int'(H)) % int'(R) == 0) r = 1;
        end
        m_press = p; m_rep = r; m_step = p | r;
        m_btn_q = button_on;
    endtask

    task automatic compare_all();
        check("press", 32'(press), 32'(m_press));
        check("repeat", 32'(repeat_pulse), 32'(m_rep));
        check("step", 32'(step), 32'(m_step));
        check("count", 32'(count_bcd), 32'(to_bcd(m_count)));
        check("changed", 32'(count_changed), 32'(m_chg));
    endtask

    task automatic tick();
        @(posedge clock);
        model_edge();
        #1;
        n_press += int'(press);
        n_rep   += int'(repeat_pulse);
        n_chg   += int'(count_changed);
        compare_all();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int p0, r0, c0, cnt0;
        model_reset();
        #1;
        check("rst_count", 32'(count_bcd), 32'h0);
        check("rst_step", 32'(step), 32'h0);
        ticks(2);
        reset_n = 1'b1;
        ticks(2);

        // Single short press
        p0 = n_press; r0 = n_rep; c0 = n_chg;
        button_on = 1'b0; ticks(3);
        button_on = 1'b1; ticks(3);
        check("one_press", 32'(n_press - p0), 32'd1);
        check("one_norep", 32'(n_rep - r0), 32'd0);
        check("one_chg", 32'(n_chg - c0), 32'd1);
        check("one_count", 32'(count_bcd), 32'h0001);

        // Long hold of 30 cycles from a cleared counter
        clear = 1'b1; tick(); clear = 1'b0; tick();
        r0 = n_rep;
        button_on = 1'b0; ticks(30);
        button_on = 1'b1; ticks(3);
        check("hold_reps", 32'(n_rep - r0), AUTO ? 32'd5 : 32'd0);
        check("hold_count", 32'(count_bcd), AUTO ? 32'h0006 : 32'h0001);

        // Release sampled on the edge a second repeat would be due
        r0 = n_rep; cnt0 = m_count;
        button_on = 1'b0; tick();
        ticks(13);
        button_on = 1'b1; tick();
        check("rel_norep", 32'(repeat_pulse), 32'd0);
        ticks(2);
        check("rel_reps", 32'(n_rep - r0), AUTO ? 32'd1 : 32'd0);
        check("rel_count", 32'(count_bcd), 32'(to_bcd(cnt0 + (AUTO ? 2 : 1))));

        // BCD carries and full wrap
        clear = 1'b1; tick(); clear = 1'b0; tick();
        for (int i = 1; i <= 10000; i++) begin
            button_on = 1'b0; tick();
            button_on = 1'b1; tick();
            if (i == 99 || i == 100 || i == 999 || i == 1000 || i == 9999 || i == 10000) begin
                check("carry", 32'(count_bcd), 32'(to_bcd(i % 10000)));
                check("carry_chg", 32'(count_changed), 32'd1);
            end
        end

        // Clear coinciding with a step at count 0042
        clear = 1'b1; tick(); clear = 1'b0; tick();
        for (int i = 0; i < 42; i++) begin
            button_on = 1'b0; tick();
            button_on = 1'b1; tick();
        end
        check("pre_clr", 32'(count_bcd), 32'h0042);
        c0 = n_chg;
        button_on = 1'b0; tick();
        check("clr_step", 32'(step), 32'd1);
        button_on = 1'b1; clear = 1'b1; tick();
        check("clr_count", 32'(count_bcd), 32'h0000);
        clear = 1'b0; ticks(2);
        check("clr_count2", 32'(count_bcd), 32'h0000);
        check("clr_chg", 32'(n_chg - c0), 32'd1);

        // Reset in the middle of a hold
        button_on = 1'b0; ticks(4);
        reset_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        ticks(2);
        reset_n = 1'b1;
        p0 = n_press;
        ticks(6);
        check("rst_nopress", 32'(n_press - p0), 32'd0);
        button_on = 1'b1; tick();
        button_on = 1'b0; tick();
        check("rst_press", 32'(press), 32'd1);
        button_on = 1'b1; ticks(3);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) button_on = ~button_on;
            clear = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 499) == 0) begin
                reset_n = 1'b0;
                #1;
                model_reset();
                compare_all();
                ticks(int'($urandom_range(1, 3)));
                reset_n = 1'b1;
            end
            tick();
        end
        clear = 1'b0;
        ticks(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/key_event.md
# key_event

Downstream consumer of the debounced key level. Converts the active-low, held `button_on` level into a single-cycle press pulse, optional auto-repeat pulses while the key is held, and a 4-digit BCD event counter that feeds the TM1637 display driver. All outputs are registered in the single `clock` domain.

## Interface

- `HOLD_CYCLES`, default 25_000_000: clock cycles from press to the first auto-repeat (0.5 s at 50 MHz); legal range ≥2.
- `REPEAT_CYCLES`, default 5_000_000: clock cycles between consecutive auto-repeats (0.1 s); legal range ≥2.
- `clock`  in  1  system clock, all logic on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `button_on`  in  1  debounced key level, 0 = pressed, 1 = released; synchronous to `clock`, no further synchronisation.
- `clear`  in  1  synchronous counter clear, active high.
- `press`  out  1  one-cycle pulse per new key press.
- `repeat_pulse`  out  1  one-cycle pulse per auto-repeat.
- `step`  out  1  `press | repeat_pulse`, registered.
- `count_bcd`  out  16  four BCD digits, [15:12] thousands … [3:0] units.
- `count_changed`  out  1  one-cycle pulse, high in the first cycle `count_bcd` shows a new value.

## Operation

- Reset values: `press`, `repeat_pulse`, `step`, `count_changed` = 0; `count_bcd` = 16'h0000; state = IDLE; `btn_q` (previous `button_on`) = 0; hold/repeat counters = 0.
- `btn_q` reset to 0 means a key already held at reset release produces no press; a release (1) then a new 0 is required.
- Press edge: `button_on` = 0 and `btn_q` = 1 at the same edge.
- FSM states IDLE, HOLD, REPEAT:
- IDLE: on press edge → `press` = 1, HOLD, hold counter cleared.
- HOLD: `button_on` = 1 → IDLE, no pulse. Otherwise hold counter increments; when it reaches HOLD_CYCLES-1 → `repeat_pulse` = 1, REPEAT, repeat counter cleared.
- REPEAT: `button_on` = 1 → IDLE, no pulse. Otherwise repeat counter increments; at REPEAT_CYCLES-1 → `repeat_pulse` = 1, counter cleared, stay REPEAT.
- Release wins over a repeat due on the same edge: no pulse.
- Counter: on each `step`, `count_bcd` increments in BCD; each digit wraps 9→0 with carry; 9999 → 0000 with no flag.
- `clear` high: `count_bcd` ← 0000 and `count_changed` = 1, regardless of `step`; `clear` wins over a simultaneous increment, and the `step` pulse itself is still emitted.
- `clear` does not affect the FSM.
- Counter widths: hold/repeat counters are $clog2 of their parameter, no overflow possible.

## Timing

- Edge k = first edge sampling the press edge: `press` and `step` high in cycle k..k+1 (one cycle).
- `count_bcd` updates at edge k+1; `count_changed` high k+1..k+2.
- First `repeat_pulse` at edge k+HOLD_CYCLES; subsequent ones every REPEAT_CYCLES edges.
- Release sampled at edge r: state IDLE from edge r; earliest next press at edge r+1.
- `reset_n` low mid-hold: immediate return to reset values; pending pulses dropped.
- `step` never high for two consecutive cycles, since both periods are ≥2.

## Configuration

- `KEY_AUTOREPEAT_EN` defined: full behaviour above, including the REPEAT state.
- Not defined: HOLD never times out. The FSM stays in HOLD until release, REPEAT is removed, `repeat_pulse` is tied 0, and `step` equals `press`. The hold/repeat counters are removed, and the HOLD_CYCLES/REPEAT_CYCLES parameters are accepted but unused.

## Test plan

Bench runs HOLD_CYCLES = 10 and REPEAT_CYCLES = 4.

- Reset, then `button_on` 1→0 for 3 cycles then 1 → exactly one `press`/`step` one cycle after the sampling edge; `count_bcd` = 0001; `count_changed` once; no `repeat_pulse`.
- Hold `button_on` = 0 for 30 cycles (macro defined) → `press` at k, repeats at k+10, k+14, k+18, k+22, k+26; `count_bcd` = 0006. Without the macro → `count_bcd` = 0001, zero repeats.
- Release on the exact edge a repeat is due (k+14) → no pulse at k+14; state IDLE; count unchanged from prior value.
- Preload to 9999 via 9999 presses (or force) then one press → `count_bcd` = 0000 and `count_changed` pulse. Also check 0099 → 0100 and 0999 → 1000 carries.
- `clear` asserted on the same edge as a `step` with count 0042 → `count_bcd` = 0000, `step` still pulses, `count_changed` once.
- `reset_n` low for 2 cycles during HOLD with key held, then released high with `button_on` still 0 → no press until `button_on` goes 1 then 0; all outputs at reset values during reset.
